// File: rtl/systolic_pkg.sv
// Shared types and sizing constants for the systolic array blocks.
// Holds the weight-loader FSM state encoding and default index and row-count widths.
// No logic of its own.
package systolic_pkg;

   localparam int SYSTOLIC_ARRAY_WIDTH = 16;
   localparam int INDEX_WIDTH          = $clog2(SYSTOLIC_ARRAY_WIDTH);
   localparam int ROWCNT_WIDTH         = INDEX_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      DRAIN  = 3'd2,
      LOADED = 3'd3,
      SWITCH = 3'd4
   } loader_state_t;

endpackage

// File: rtl/switch_skew_chain.sv
// Row-skewed switch pulse generator: a single 1 walks from bit 0 to bit N-1, one row per cycle.
// Latency: bit r is high in cycle trigger+1+r; done_o pulses in cycle trigger+N+1.
// Ports: clk_i/rst_i (sync, active-high), trigger_i pulse in, row_switch_o one-hot out, done_o pulse out.
module switch_skew_chain #(
   parameter int N = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         trigger_i,
   output logic [N-1:0] row_switch_o,
   output logic         done_o
);

   logic [N-1:0] sr_q;
   logic         done_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q   <= '0;
         done_q <= 1'b0;
      end else begin
         // The trigger only arrives while the chain is empty, so load rather than OR.
         if (trigger_i) begin
            sr_q <= N'(1);
         end else begin
            sr_q <= sr_q << 1;
         end
         // Pulse one cycle after the token leaves the last row.
         done_q <= sr_q[N-1];
      end
   end

   assign row_switch_o = sr_q;
   assign done_o       = done_q;

endmodule

// File: rtl/weight_loader.sv
// Weight-injection front end: streams tile rows to the array north edge, then drives a row-skewed switch.
// Latency: beat accepted in cycle t appears on col_* in t+1; rows beyond num_rows are zero-padded one per cycle.
// Ports: wt_valid_in/wt_ready_out source handshake; col_* to row-0 PEs; row_switch_out to column-0 PEs; status levels/pulses.
module weight_loader
   import systolic_pkg::*;
#(
   parameter  int SYSTOLIC_ARRAY_WIDTH = 16,
   parameter  int DATA_WIDTH_IN        = 8,
   parameter  int DRAIN_CYCLES         = SYSTOLIC_ARRAY_WIDTH,
   localparam int N    = SYSTOLIC_ARRAY_WIDTH,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
   localparam int RC_W = IDX_W + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load_start_in,
   input  logic [RC_W-1:0]              num_rows_in,
   input  logic                         wt_valid_in,
   output logic                         wt_ready_out,
   input  logic [N*DATA_WIDTH_IN-1:0]   wt_row_in,
   input  logic [N-1:0]                 col_enable_in,
   output logic [N*DATA_WIDTH_IN-1:0]   col_weight_out,
   output logic [N*IDX_W-1:0]           col_index_out,
   output logic [N-1:0]                 col_accept_w_out,
   input  logic                         switch_req_in,
   output logic [N-1:0]                 row_switch_out,
   output logic                         loaded_out,
   output logic                         switch_done_out,
   output logic                         busy_out
);

   localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

   // The last index needs N-1 edges to ripple down to row N-1 before the tile is resident.
   if (DRAIN_CYCLES < N - 1) begin : g_drain_too_short
      $error("weight_loader: DRAIN_CYCLES must be at least SYSTOLIC_ARRAY_WIDTH-1");
   end

   loader_state_t              state_q, state_d;
   logic [RC_W-1:0]            k_q, k_d;        // next row index to emit
   logic [RC_W-1:0]            r_q, r_d;        // rows supplied by the source
   logic [DC_W-1:0]            dcnt_q, dcnt_d;
   logic [N*DATA_WIDTH_IN-1:0] wdat_q, wdat_d;
   logic [N*IDX_W-1:0]         idx_q, idx_d;
   logic [N-1:0]               acc_q, acc_d;
   logic                       wt_ready;
   logic                       emit;
   logic                       switch_trig;
   logic [N-1:0]               row_switch;
   logic                       switch_done;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      r_d         = r_q;
      dcnt_d      = dcnt_q;
      wdat_d      = '0;
      idx_d       = '0;
      acc_d       = '0;
      wt_ready    = 1'b0;
      emit        = 1'b0;
      switch_trig = 1'b0;

      case (state_q)
         IDLE: begin
            if (load_start_in) begin
               // Zero or an oversize count both mean a full tile.
               if (num_rows_in == '0 || num_rows_in > RC_W'(N)) begin
                  r_d = RC_W'(N);
               end else begin
                  r_d = num_rows_in;
               end
               k_d     = '0;
               state_d = LOAD;
            end
         end

         LOAD: begin
            wt_ready = (k_q < r_q);
            if (wt_ready) begin
               if (wt_valid_in) begin
                  emit   = 1'b1;
                  wdat_d = wt_row_in;
               end
            end else begin
               // Source exhausted: pad the remaining rows with zero weights.
               emit = 1'b1;
            end

            if (emit) begin
               idx_d = {N{k_q[IDX_W-1:0]}};
               acc_d = col_enable_in;
               k_d   = k_q + 1'b1;
               if (k_q == RC_W'(N - 1)) begin
                  k_d     = '0;
                  dcnt_d  = '0;
                  state_d = DRAIN;
               end
            end
         end

         DRAIN: begin
            if (dcnt_q == DC_W'(DRAIN_CYCLES - 1)) begin
               state_d = LOADED;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end

         LOADED: begin
            if (switch_req_in) begin
               switch_trig = 1'b1;
               state_d     = SWITCH;
            end
         end

         SWITCH: begin
            // Leaving as the last row switches makes the done-pulse cycle an IDLE cycle,
            // so a back-to-back load_start_in is honoured there.
            if (row_switch[N-1]) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         r_q     <= '0;
         dcnt_q  <= '0;
         wdat_q  <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         r_q     <= r_d;
         dcnt_q  <= dcnt_d;
         wdat_q  <= wdat_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
      end
   end

   switch_skew_chain #(
      .N (N)
   ) u_skew (
      .clk_i        (clk),
      .rst_i        (rst),
      .trigger_i    (switch_trig),
      .row_switch_o (row_switch),
      .done_o       (switch_done)
   );

   assign wt_ready_out     = wt_ready;
   assign col_weight_out   = wdat_q;
   assign col_index_out    = idx_q;
   assign col_accept_w_out = acc_q;
   assign row_switch_out   = row_switch;
   assign switch_done_out  = switch_done;
   assign loaded_out       = (state_q == LOADED) || (state_q == SWITCH);
   assign busy_out         = (state_q != IDLE);

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader at N=4: random tiles checked against a row-stream model and a PE-array model.
// Covers reset, full and short tiles, source stalls, disabled columns, switch skew, back-to-back, mid-load reset.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_weight_loader;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int IW = 2;
   localparam int RW = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            load_start_in;
   logic [RW-1:0]   num_rows_in;
   logic            wt_valid_in;
   logic            wt_ready_out;
   logic [N*W-1:0]  wt_row_in;
   logic [N-1:0]    col_enable_in;
   logic [N*W-1:0]  col_weight_out;
   logic [N*IW-1:0] col_index_out;
   logic [N-1:0]    col_accept_w_out;
   logic            switch_req_in;
   logic [N-1:0]    row_switch_out;
   logic            loaded_out;
   logic            switch_done_out;
   logic            busy_out;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] src   [N][N];   // source rows for the current tile
   logic [W-1:0] inact [N][N];   // inactive registers of the PE array [row][col]
   logic [W-1:0] expt  [N][N];   // expected inactive contents after the tile

   always #5 clk = ~clk;

   weight_loader #(
      .SYSTOLIC_ARRAY_WIDTH (N),
      .DATA_WIDTH_IN        (W),
      .DRAIN_CYCLES         (D)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .load_start_in    (load_start_in),
      .num_rows_in      (num_rows_in),
      .wt_valid_in      (wt_valid_in),
      .wt_ready_out     (wt_ready_out),
      .wt_row_in        (wt_row_in),
      .col_enable_in    (col_enable_in),
      .col_weight_out   (col_weight_out),
      .col_index_out    (col_index_out),
      .col_accept_w_out (col_accept_w_out),
      .switch_req_in    (switch_req_in),
      .row_switch_out   (row_switch_out),
      .loaded_out       (loaded_out),
      .switch_done_out  (switch_done_out),
      .busy_out         (busy_out)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Checks the north-edge outputs and lets the PE array model capture accepted weights.
   task automatic chk_cols(input logic [N*W-1:0] ew, input logic [N*IW-1:0] ei, input logic [N-1:0] ea);
      chk("col_weight", 64'(col_weight_out), 64'(ew));
      chk("col_index", 64'(col_index_out), 64'(ei));
      chk("col_accept", 64'(col_accept_w_out), 64'(ea));
      for (int c = 0; c < N; c++) begin
         if (col_accept_w_out[c] === 1'b1)
            inact[col_index_out[c*IW +: IW]][c] = col_weight_out[c*W +: W];
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 64'(wt_ready_out), '0);
      chk({tag, "_weight"}, 64'(col_weight_out), '0);
      chk({tag, "_index"}, 64'(col_index_out), '0);
      chk({tag, "_accept"}, 64'(col_accept_w_out), '0);
      chk({tag, "_rowsw"}, 64'(row_switch_out), '0);
      chk({tag, "_loaded"}, 64'(loaded_out), '0);
      chk({tag, "_done"}, 64'(switch_done_out), '0);
      chk({tag, "_busy"}, 64'(busy_out), '0);
   endtask

   // One full tile: IDLE start through LOADED, then the array contents are compared.
   task automatic run_load(input logic [RW-1:0] raw, input logic [N-1:0] en, input int vprob,
                           input bit fixed, input bit noise);
      int rn, emitted, cyc;
      logic [N*W-1:0]  ew;
      logic [N*IW-1:0] ei;
      logic [N-1:0]    ea;
      logic [N*W-1:0]  row;
      rn = (raw == 0 || int'(raw) > N) ? N : int'(raw);
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            src[r][c]  = fixed ? W'(r + 1) : W'($urandom);
            expt[r][c] = en[c] ? ((r < rn) ? src[r][c] : '0) : inact[r][c];
         end
      end
      chk("start_busy", 64'(busy_out), '0);
      load_start_in = 1'b1;
      num_rows_in   = raw;
      col_enable_in = en;
      tick;
      load_start_in = 1'b0;
      num_rows_in   = RW'($urandom);
      ew = '0; ei = '0; ea = '0;
      emitted = 0;
      cyc     = 0;
      while (emitted < N && cyc < 200) begin
         chk_cols(ew, ei, ea);
         chk("load_busy", 64'(busy_out), 64'(1));
         chk("load_loaded", 64'(loaded_out), '0);
         chk("load_rowsw", 64'(row_switch_out), '0);
         ew = '0; ei = '0; ea = '0;
         switch_req_in = noise && ($urandom_range(0, 1) == 1);
         load_start_in = noise && ($urandom_range(0, 3) == 0);
         if (emitted < rn) begin
            chk("ready_src", 64'(wt_ready_out), 64'(1));
            for (int c = 0; c < N; c++) row[c*W +: W] = src[emitted][c];
            wt_row_in   = row;
            wt_valid_in = (int'($urandom_range(0, 99)) < vprob);
            if (wt_valid_in) begin
               ew = row;
               ei = {N{emitted[IW-1:0]}};
               ea = en;
               emitted++;
            end
         end else begin
            chk("ready_pad", 64'(wt_ready_out), '0);
            wt_valid_in = ($urandom_range(0, 1) == 1);
            wt_row_in   = $urandom;
            ei = {N{emitted[IW-1:0]}};
            ea = en;
            emitted++;
         end
         tick;
         cyc++;
      end
      chk("load_emissions", 64'(emitted), 64'(N));
      chk_cols(ew, ei, ea);
      chk("drain_first_loaded", 64'(loaded_out), '0);
      switch_req_in = 1'b0;
      load_start_in = 1'b0;
      for (int i = 1; i < D; i++) begin
         wt_valid_in = ($urandom_range(0, 1) == 1);
         tick;
         chk_cols('0, '0, '0);
         chk("drain_loaded", 64'(loaded_out), '0);
         chk("drain_ready", 64'(wt_ready_out), '0);
         chk("drain_busy", 64'(busy_out), 64'(1));
      end
      wt_valid_in = 1'b0;
      tick;
      chk("loaded", 64'(loaded_out), 64'(1));
      chk("loaded_ready", 64'(wt_ready_out), '0);
      chk_cols('0, '0, '0);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            chk($sformatf("tile_r%0d_c%0d", r, c), 64'(inact[r][c]), 64'(expt[r][c]));
   endtask

   // Issues the switch after 'pre' idle LOADED cycles; ends in the switch_done cycle.
   task automatic run_switch(input int pre);
      logic [N-1:0] onehot;
      switch_req_in = 1'b0;
      for (int i = 0; i < pre; i++) begin
         tick;
         chk("wait_loaded", 64'(loaded_out), 64'(1));
         chk("wait_rowsw", 64'(row_switch_out), '0);
      end
      switch_req_in = 1'b1;
      tick;
      switch_req_in = 1'b0;
      for (int r = 0; r < N; r++) begin
         onehot = '0;
         onehot[r] = 1'b1;
         chk($sformatf("rowsw_%0d", r), 64'(row_switch_out), 64'(onehot));
         chk("sw_done_early", 64'(switch_done_out), '0);
         chk("sw_loaded", 64'(loaded_out), 64'(1));
         tick;
      end
      chk("sw_rowsw_end", 64'(row_switch_out), '0);
      chk("sw_done", 64'(switch_done_out), 64'(1));
      chk("sw_loaded_end", 64'(loaded_out), '0);
      chk("sw_busy_end", 64'(busy_out), '0);
   endtask

   initial begin
      rst           = 1'b1;
      load_start_in = 1'b0;
      num_rows_in   = '0;
      wt_valid_in   = 1'b0;
      wt_row_in     = '0;
      col_enable_in = '0;
      switch_req_in = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            inact[r][c] = '0;

      tick;
      tick;
      chk_all_zero("reset");
      rst = 1'b0;
      tick;
      chk_all_zero("post_reset");

      // Full tile with rows 1..4, then switch and a back-to-back short tile.
      run_load(3'd4, 4'b1111, 100, 1'b1, 1'b0);
      run_switch(2);
      run_load(3'd2, 4'b1111, 100, 1'b0, 1'b0);
      run_switch(0);
      tick;

      // Stalling source, then disabled columns with switch/start noise during load.
      run_load(3'd4, 4'b1111, 40, 1'b0, 1'b0);
      run_switch(1);
      tick;
      run_load(3'd0, 4'b0101, 60, 1'b0, 1'b1);
      run_switch(3);

      for (int t = 0; t < 6; t++) begin
         run_load(RW'($urandom), N'($urandom), 30 + $urandom_range(0, 70), 1'b0, 1'b1);
         run_switch($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) tick;
      end

      // Reset during the load: abort, then a fresh load completes.
      tick;
      load_start_in = 1'b1;
      num_rows_in   = 3'd4;
      col_enable_in = 4'b1111;
      tick;
      load_start_in = 1'b0;
      wt_valid_in   = 1'b1;
      wt_row_in     = $urandom;
      tick;
      tick;
      rst = 1'b1;
      tick;
      chk_all_zero("midload_reset");
      rst         = 1'b0;
      wt_valid_in = 1'b0;
      tick;
      chk_all_zero("after_abort");
      run_load(3'd7, 4'b1111, 70, 1'b0, 1'b1);
      run_switch(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Weight-injection front end for the systolic array.
- Drives the north edge of every column with the weight/index/accept_w stream that PEs consume: the PE whose ROW_ID matches the index captures the weight into its inactive register and swallows the token.
- After the tile has been fully delivered, drives a row-skewed switch pulse on the west edge so each row promotes inactive to active.
- Sits between the tile-load controller/weight buffer and the array.

Parameters:
- SYSTOLIC_ARRAY_WIDTH, 16, array rows = columns (N).
- DATA_WIDTH_IN, 8, signed weight width.
- DRAIN_CYCLES, SYSTOLIC_ARRAY_WIDTH, wait after the last emission before the tile counts as resident.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- load_start_in  in  1  pulse; begins a tile load (honoured in IDLE only).
- num_rows_in  in  $clog2(N)+1  rows supplied by the source, sampled with load_start_in; 0 or >N means N.
- wt_valid_in  in  1  source row beat valid.
- wt_ready_out  out  1  loader accepts a beat.
- wt_row_in  in  N*DATA_WIDTH_IN  one weight per column; column c at bits [c*W +: W].
- col_enable_in  in  N  column enables, same vector the array uses.
- col_weight_out  out  N*DATA_WIDTH_IN  to pe_weight_in of row-0 PEs.
- col_index_out  out  N*$clog2(N)  to pe_index_in of row-0 PEs.
- col_accept_w_out  out  N  to pe_accept_w_in of row-0 PEs.
- switch_req_in  in  1  pulse; controller permits the weight swap.
- row_switch_out  out  N  to pe_switch_in of column-0 PEs.
- loaded_out  out  1  level; tile resident in the inactive registers.
- switch_done_out  out  1  one-cycle pulse after the last row switch.
- busy_out  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE. Every output is 0, including wt_ready_out, loaded_out, busy_out and all col_*/row_switch outputs. Reset mid-load or mid-switch aborts immediately. PE inactive contents are then undefined and the controller must reload.
- States:
  - IDLE: load_start_in latches R (num_rows, normalized) and goes to LOAD with k=0. All other inputs are ignored.
  - LOAD: wt_ready_out=1 while k<R. On wt_valid_in&&wt_ready_out (cycle t), at t+1:
    - col_weight_out = wt_row_in
    - col_index_out[c] = k for every column
    - col_accept_w_out = col_enable_in
    - then k++.
    - No beat in a cycle: col_accept_w_out=0, weight and index outputs 0.
    - When R beats have been taken and R<N, the loader self-pads rows R..N-1, one per cycle, with weight 0, accept = col_enable_in and wt_ready_out=0. No handshake is involved.
    - After index N-1 is emitted, go to DRAIN.
  - DRAIN: counter runs DRAIN_CYCLES cycles with col outputs idle, then go to LOADED.
    - Index N-1 emitted at cycle e is captured by row N-1 at edge e+N-1, so DRAIN_CYCLES ≥ N-1 is required. This is a static assertion.
  - LOADED: loaded_out=1. switch_req_in at cycle s goes to SWITCH.
  - SWITCH: row_switch_out[r]=1 for exactly cycle s+1+r, r=0..N-1, one-hot and never overlapping. This matches the row skew of the activation feeder. At cycle s+N+1: switch_done_out=1, loaded_out=0, return to IDLE.
- Ignored inputs:
  - switch_req_in outside LOADED.
  - load_start_in outside IDLE.
  - wt_valid_in outside LOAD.
- Back-to-back tiles: a load_start_in in the switch_done_out cycle is accepted. It is safe because each row has already swapped.
- A disabled column gets accept=0 for the whole load. Its weight and index outputs still carry data, which the PE ignores.
- Index width is $clog2(N); k never exceeds N-1.

Decomposition:
- Package systolic_pkg:
  - INDEX_WIDTH = $clog2(SYSTOLIC_ARRAY_WIDTH)
  - ROWCNT_WIDTH = INDEX_WIDTH+1
  - typedef enum loader_state_t {IDLE, LOAD, DRAIN, LOADED, SWITCH}
- One sub-module, switch_skew_chain: an N-bit shift register. It injects a 1 at bit 0 on a trigger and shifts it toward bit N-1 each cycle. It also produces the done pulse.

Test Plan:
- N=4, R=4, rows {1,2,3,4}×col, valid held, enables all 1 → 4 cycles of accept=4'b1111 with index 0,1,2,3 → DRAIN (4) → loaded_out=1; array model shows row r inactive = r+1.
- R=2 → rows 0,1 loaded from the source; rows 2,3 padded with 0 with wt_ready_out=0 during padding; exactly 4 emissions total.
- Source stalls with wt_valid_in toggling 1,0,0,1,... → no emission in gap cycles, indices contiguous 0..3, output unchanged in count.
- col_enable_in=4'b0101 → col_accept_w_out=4'b0101 on every emission; columns 1 and 3 PEs keep old inactive.
- switch_req_in at cycle s in LOADED → row_switch_out = 0001, 0010, 0100, 1000 at s+1..s+4; switch_done_out at s+5; switch_req_in issued during LOAD has no effect.
- rst asserted during LOAD beat 2 → next cycle all outputs 0, state IDLE; a fresh load_start_in then completes normally.
